// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic result buffer: op encoding, queue entry layout
// and the per-entry result select / status flag function.
// Purely combinational helpers; no state and no backpressure.
package arith_pkg;

    // Op select encoding as driven by the upstream arithmetic unit
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    // Result reported for a divide by zero; the unit's own quotient is meaningless then
    localparam logic [7:0] DIV0_RESULT = 8'hFF;

    // 8 result + 2 op + 3 flags
    localparam int ENTRY_W = 13;

    // One queued result; field order defines the packed storage layout
    typedef struct packed {
        logic [7:0] result;
        logic [1:0] op;
        logic       carry;
        logic       zero;
        logic       div0;
    } entry_t;

    // Pick the result for the selected op and derive its flags.
    // zero is taken from the final result, so a div-by-zero entry (0xFF) never reports zero.
    function automatic entry_t make_entry(
        input logic [1:0] op,
        input logic [7:0] value_a,
        input logic [7:0] value_b,
        input logic [7:0] value_add,
        input logic [7:0] value_sub,
        input logic [7:0] value_mul,
        input logic [7:0] value_div
    );
        entry_t e;
        e = '0;
        e.op = op;
        case (op)
            OP_ADD: begin
                e.result = value_add;
                // an 8-bit sum that wrapped is smaller than either operand
                e.carry  = (value_add < value_a);
            end
            OP_SUB: begin
                e.result = value_sub;
                // borrow out of a - b
                e.carry  = (value_a < value_b);
            end
            OP_MUL: begin
                // product is truncated; overflow is deliberately not flagged
                e.result = value_mul;
            end
            default: begin
                if (value_b == 8'd0) begin
                    e.result = DIV0_RESULT;
                    e.div0   = 1'b1;
                end else begin
                    e.result = value_div;
                end
            end
        endcase
        e.zero = (e.result == 8'd0);
        return e;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with registered storage, wrapping pointers and an occupancy counter.
// Latency: a write is visible on rd_dat/rd_vld the cycle after it is accepted; no bypass.
// Backpressure: wr_rdy is !full from registered occupancy, so a same-cycle read never frees a slot early.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_vld,
    output logic             wr_rdy,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = AW + 1;

    typedef logic [AW-1:0]    ptr_t;
    typedef logic [OCC_W-1:0] occ_t;

    logic [WIDTH-1:0] mem [DEPTH];
    ptr_t             wr_ptr;
    ptr_t             rd_ptr;
    occ_t             occ;
    logic             full;
    logic             empty;
    logic             do_wr;
    logic             do_rd;

    assign full   = (occ == occ_t'(DEPTH));
    assign empty  = (occ == occ_t'(0));
    assign wr_rdy = !full;
    assign rd_vld = !empty;
    assign do_wr  = wr_vld && !full;
    assign do_rd  = rd_rdy && !empty;
    assign rd_dat = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH (power of two)
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + ptr_t'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   occ <= occ + occ_t'(1);
                2'b01:   occ <= occ - occ_t'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Storage write; contents need no reset because occupancy gates what is read
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

endmodule

// File: rtl/arith_result_buffer.sv
// Selects one arithmetic-unit result per input, flags it and queues it for a valid/ready consumer.
// Latency: pushed entry appears on o_valid/o_result one cycle later; no same-cycle bypass.
// Backpressure: o_ready = not full; input is dropped while full even if a pop happens that cycle.
module arith_result_buffer
    import arith_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_op,
    input  logic [7:0]       i_value_a,
    input  logic [7:0]       i_value_b,
    input  logic [7:0]       i_value_add,
    input  logic [7:0]       i_value_sub,
    input  logic [7:0]       i_value_mul,
    input  logic [7:0]       i_value_div,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [7:0]       o_result,
    output logic [1:0]       o_op,
    output logic             o_flag_carry,
    output logic             o_flag_zero,
    output logic             o_flag_div0,
    output logic [CNT_W-1:0] o_count
);

    entry_t     new_entry;
    entry_t     head_entry;
    entry_t     held_entry;
    entry_t     shown_entry;
    logic       fifo_rdy;
    logic       fifo_vld;
    logic       pop;
    logic [ENTRY_W-1:0] head_bits;

    // Result select and flag generation for the incoming set of unit outputs
    always_comb begin
        new_entry = make_entry(i_op, i_value_a, i_value_b, i_value_add,
                               i_value_sub, i_value_mul, i_value_div);
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_vld (i_valid),
        .wr_rdy (fifo_rdy),
        .wr_dat (new_entry),
        .rd_vld (fifo_vld),
        .rd_rdy (i_ready),
        .rd_dat (head_bits)
    );

    assign head_entry = entry_t'(head_bits);
    assign o_ready    = fifo_rdy;
    assign o_valid    = fifo_vld;
    assign pop        = fifo_vld && i_ready;

    // Keep a copy of the last delivered entry so outputs hold steady (and read 0 after reset) when empty
    always_ff @(posedge clk) begin
        if (reset) begin
            held_entry <= '0;
        end else if (pop) begin
            held_entry <= head_entry;
        end
    end

    // Count delivered results; wraps at 2^CNT_W
    always_ff @(posedge clk) begin
        if (reset) begin
            o_count <= '0;
        end else if (pop) begin
            o_count <= o_count + CNT_W'(1);
        end
    end

    // Head outputs come straight from storage while valid, otherwise from the held copy
    always_comb begin
        shown_entry  = fifo_vld ? head_entry : held_entry;
        o_result     = shown_entry.result;
        o_op         = shown_entry.op;
        o_flag_carry = shown_entry.carry;
        o_flag_zero  = shown_entry.zero;
        o_flag_div0  = shown_entry.div0;
    end

endmodule

// File: tb/tb_arith_result_buffer.sv
module tb_arith_result_buffer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_valid = 1'b0;
    logic       o_ready;
    logic [1:0] i_op = 2'd0;
    logic [7:0] i_value_a = 8'd0;
    logic [7:0] i_value_b = 8'd0;
    logic [7:0] i_value_add = 8'd0;
    logic [7:0] i_value_sub = 8'd0;
    logic [7:0] i_value_mul = 8'd0;
    logic [7:0] i_value_div = 8'd0;
    logic       o_valid;
    logic       i_ready = 1'b1;
    logic [7:0] o_result;
    logic [1:0] o_op;
    logic       o_flag_carry;
    logic       o_flag_zero;
    logic       o_flag_div0;
    logic [7:0] o_count;

    int total = 0;
    int bad = 0;
    int mcount = 0;
    logic [12:0] exp_q [$];
    logic last_vld_at_push;
    bit acc;

    arith_result_buffer #(.DEPTH(4), .CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_op         (i_op),
        .i_value_a    (i_value_a),
        .i_value_b    (i_value_b),
        .i_value_add  (i_value_add),
        .i_value_sub  (i_value_sub),
        .i_value_mul  (i_value_mul),
        .i_value_div  (i_value_div),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_result     (o_result),
        .o_op         (o_op),
        .o_flag_carry (o_flag_carry),
        .o_flag_zero  (o_flag_zero),
        .o_flag_div0  (o_flag_div0),
        .o_count      (o_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the edge that samples the push.
    task automatic push(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] vadd, input logic [7:0] vsub,
                        input logic [7:0] vmul, input logic [7:0] vdiv,
                        input logic [7:0] er, input logic ec, input logic ez,
                        input logic ed, output bit accepted);
        i_valid     = 1'b1;
        i_op        = op;
        i_value_a   = a;
        i_value_b   = b;
        i_value_add = vadd;
        i_value_sub = vsub;
        i_value_mul = vmul;
        i_value_div = vdiv;
        @(negedge clk);
        accepted = o_ready;
        last_vld_at_push = o_valid;
        @(posedge clk);
        if (accepted) exp_q.push_back({er, op, ec, ez, ed});
        #1;
        i_valid = 1'b0;
    endtask

    task automatic do_reset();
        i_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compares every delivered entry against the scoreboard queue
    always @(negedge clk) begin
        logic [12:0] e;
        if (reset) begin
            exp_q.delete();
            mcount = 0;
        end else if (o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("result", int'(o_result), int'(e[12:5]));
                chk("op", int'(o_op), int'(e[4:3]));
                chk("carry", int'(o_flag_carry), int'(e[2]));
                chk("zero", int'(o_flag_zero), int'(e[1]));
                chk("div0", int'(o_flag_div0), int'(e[0]));
            end
            chk("count", int'(o_count), mcount);
            mcount = (mcount + 1) % 256;
        end
    end

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_ready", int'(o_ready), 1);
        chk("rst_count", int'(o_count), 0);
        chk("rst_result", int'(o_result), 0);
        chk("rst_flags", int'({o_op, o_flag_carry, o_flag_zero, o_flag_div0}), 0);

        // 1: a=20 b=10, all four ops
        i_ready = 1'b1;
        push(2'd0, 8'd20, 8'd10, 8'd30, 8'd10, 8'd200, 8'd2, 8'd30, 1'b0, 1'b0, 1'b0, acc);
        chk("t1_no_bypass", int'(last_vld_at_push), 0);
        chk("t1_lat_add", int'(o_valid), 1);
        push(2'd1, 8'd20, 8'd10, 8'd30, 8'd10, 8'd200, 8'd2, 8'd10, 1'b0, 1'b0, 1'b0, acc);
        chk("t1_lat_sub", int'(o_valid), 1);
        push(2'd2, 8'd20, 8'd10, 8'd30, 8'd10, 8'd200, 8'd2, 8'd200, 1'b0, 1'b0, 1'b0, acc);
        chk("t1_lat_mul", int'(o_valid), 1);
        push(2'd3, 8'd20, 8'd10, 8'd30, 8'd10, 8'd200, 8'd2, 8'd2, 1'b0, 1'b0, 1'b0, acc);
        chk("t1_lat_div", int'(o_valid), 1);
        idle(3);
        chk("t1_count", int'(o_count), 4);
        chk("t1_empty", int'(o_valid), 0);
        chk("t1_hold_last", int'(o_result), 2);

        // 2: carry and borrow
        push(2'd0, 8'd200, 8'd100, 8'd44, 8'd100, 8'd32, 8'd2, 8'd44, 1'b1, 1'b0, 1'b0, acc);
        push(2'd1, 8'd10, 8'd20, 8'd30, 8'd246, 8'd200, 8'd0, 8'd246, 1'b1, 1'b0, 1'b0, acc);
        // 3: divide by zero, zero result, truncated product
        push(2'd3, 8'd20, 8'd0, 8'd20, 8'd20, 8'd0, 8'd0, 8'hFF, 1'b0, 1'b0, 1'b1, acc);
        push(2'd1, 8'd5, 8'd5, 8'd10, 8'd0, 8'd25, 8'd1, 8'd0, 1'b0, 1'b1, 1'b0, acc);
        push(2'd2, 8'd20, 8'd20, 8'd40, 8'd0, 8'd144, 8'd1, 8'd144, 1'b0, 1'b0, 1'b0, acc);
        idle(3);

        // 4: fill to full with consumer stalled
        i_ready = 1'b0;
        push(2'd0, 8'd10, 8'd1, 8'd11, 8'd9, 8'd10, 8'd10, 8'd11, 1'b0, 1'b0, 1'b0, acc);
        push(2'd0, 8'd20, 8'd1, 8'd21, 8'd19, 8'd20, 8'd20, 8'd21, 1'b0, 1'b0, 1'b0, acc);
        push(2'd0, 8'd30, 8'd1, 8'd31, 8'd29, 8'd30, 8'd30, 8'd31, 1'b0, 1'b0, 1'b0, acc);
        push(2'd0, 8'd40, 8'd1, 8'd41, 8'd39, 8'd40, 8'd40, 8'd41, 1'b0, 1'b0, 1'b0, acc);
        chk("t4_4th_acc", int'(acc), 1);
        chk("t4_full_ready", int'(o_ready), 0);
        push(2'd0, 8'd50, 8'd1, 8'd51, 8'd49, 8'd50, 8'd50, 8'd51, 1'b0, 1'b0, 1'b0, acc);
        chk("t4_5th_ignored", int'(acc), 0);
        @(negedge clk);
        chk("t4_stable_a", int'(o_result), 11);
        @(negedge clk);
        chk("t4_stable_b", int'(o_result), 11);
        @(posedge clk);
        #1;
        i_ready = 1'b1;
        @(negedge clk);
        chk("t4_ready_pop_cycle", int'(o_ready), 0);
        @(posedge clk);
        #1;
        chk("t4_ready_after_pop", int'(o_ready), 1);
        idle(5);
        chk("t4_drained", int'(o_valid), 0);
        chk("t4_queue_empty", exp_q.size(), 0);

        // 5: streaming at occupancy 2 for 300 deliveries
        do_reset();
        i_ready = 1'b0;
        for (int i = 0; i < 300; i++) begin
            logic [7:0] a;
            logic [7:0] s;
            a = i[7:0];
            s = a + 8'd1;
            if (i == 2) i_ready = 1'b1;
            push(2'd0, a, 8'd1, s, 8'h5A, 8'hA5, 8'h3C, s,
                 (a == 8'd255), (s == 8'd0), 1'b0, acc);
            chk("t5_acc", int'(acc), 1);
        end
        idle(4);
        chk("t5_queue_empty", exp_q.size(), 0);
        chk("t5_count_wrapped", int'(o_count), 44);

        // 6: reset with entries queued
        i_ready = 1'b0;
        push(2'd0, 8'd1, 8'd1, 8'd2, 8'd0, 8'd1, 8'd1, 8'd2, 1'b0, 1'b0, 1'b0, acc);
        push(2'd0, 8'd2, 8'd1, 8'd3, 8'd1, 8'd2, 8'd2, 8'd3, 1'b0, 1'b0, 1'b0, acc);
        push(2'd0, 8'd3, 8'd1, 8'd4, 8'd2, 8'd3, 8'd3, 8'd4, 1'b0, 1'b0, 1'b0, acc);
        do_reset();
        chk("t6_valid", int'(o_valid), 0);
        chk("t6_ready", int'(o_ready), 1);
        chk("t6_count", int'(o_count), 0);
        chk("t6_result", int'(o_result), 0);
        i_ready = 1'b1;
        push(2'd2, 8'd7, 8'd3, 8'd10, 8'd4, 8'd21, 8'd2, 8'd21, 1'b0, 1'b0, 1'b0, acc);
        chk("t6_no_bypass", int'(last_vld_at_push), 0);
        chk("t6_latency", int'(o_valid), 1);
        idle(3);
        chk("t6_queue_empty", exp_q.size(), 0);
        chk("t6_count_after", int'(o_count), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
